// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if
// Groups the scheduler's handshake signals into one bundle:
//   write request : wr_req, wr_addr, wr_data -> wr_ack
//   access engine : acc_start, acc_wr, acc_addr, acc_wdata -> acc_done, acc_rdata
//   read results  : rd_valid, rd_index, rd_data
// Modports:
//   master - the scheduler (drives acc_*, wr_ack, rd_*)
//   slave  - the surrounding logic (register requester, engine, memory bank)
interface rtc_bus_scheduler_if;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;

    logic       acc_start;
    logic       acc_wr;
    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_done;
    logic [7:0] acc_rdata;

    logic       rd_valid;
    logic [3:0] rd_index;
    logic [7:0] rd_data;

    modport master (
        input  wr_req, wr_addr, wr_data, acc_done, acc_rdata,
        output wr_ack, acc_start, acc_wr, acc_addr, acc_wdata,
               rd_valid, rd_index, rd_data
    );

    modport slave (
        output wr_req, wr_addr, wr_data, acc_done, acc_rdata,
        input  wr_ack, acc_start, acc_wr, acc_addr, acc_wdata,
               rd_valid, rd_index, rd_data
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
// Sequences all RTC bus accesses through the access engine: two init writes
// after reset, then periodic read sweeps over the time/date/timer registers,
// with configuration writes slotted in between sweep accesses.
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-low reset
//   tick_refresh - one-cycle request for a read sweep
//   bus          - rtc_bus_scheduler_if.master (write request, engine, read results)
//   sweep_done   - one-cycle pulse after the last read of a sweep
//   busy         - high in every state except IDLE
//   timeout_err  - sticky watchdog flag
// Optional feature: define RTC_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise WAIT waits indefinitely and timeout_err is 0.
//
// state      | meaning
// INIT_W0    | issue init write 0x02 <- 0x10
// INIT_WAIT0 | wait for engine on first init write
// INIT_W1    | issue init write 0x02 <- 0x00
// INIT_WAIT1 | wait for engine on second init write
// IDLE       | nothing to do
// ISSUE_WR   | acc_start for a requested write
// WAIT_WR    | wait for engine on requested write
// WR_ACK     | wr_ack pulse
// ISSUE_RD   | acc_start for sweep read at pointer
// WAIT_RD    | wait for engine on sweep read
// RD_OUT     | rd_valid pulse with captured byte
// NEXT       | pick write / next read / end of sweep
module rtc_bus_scheduler #(
    parameter int SWEEP_LEN      = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick_refresh,
    rtc_bus_scheduler_if.master      bus,
    output logic                     sweep_done,
    output logic                     busy,
    output logic                     timeout_err
);

    typedef enum logic [3:0] {
        INIT_W0, INIT_WAIT0, INIT_W1, INIT_WAIT1, IDLE,
        ISSUE_WR, WAIT_WR, WR_ACK, ISSUE_RD, WAIT_RD, RD_OUT, NEXT
    } state_t;

    localparam logic [3:0] SWEEP_END = 4'(SWEEP_LEN);

    state_t     state, next_state;
    logic       live;          // low only in the cycle(s) right after reset, keeps outputs quiet
    logic [3:0] ptr;
    logic       pending;
    logic       sweep_active;
    logic [7:0] wr_addr_q, wr_data_q, rdata_q;
    logic       abandon;
    logic       more_reads;

    function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h27;
            4'd7:    return 8'h41;
            4'd8:    return 8'h42;
            4'd9:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    assign more_reads = sweep_active && (ptr < SWEEP_END);

`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          in_wait;
    logic          err_q;

    assign in_wait = (state == INIT_WAIT0) || (state == INIT_WAIT1) ||
                     (state == WAIT_WR)    || (state == WAIT_RD);
    // Count 0..TIMEOUT_CYCLES-1 covers TIMEOUT_CYCLES wait cycles.
    assign abandon = in_wait && !bus.acc_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_wait && !abandon) wait_cnt <= wait_cnt + 1'b1;
            else                     wait_cnt <= '0;
            if (abandon) err_q <= 1'b1;
        end
    end
    assign timeout_err = err_q;
`else
    assign abandon     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= INIT_W0;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT_W0:    if (live) next_state = INIT_WAIT0;
            INIT_WAIT0: if (bus.acc_done || abandon) next_state = INIT_W1;
            INIT_W1:    next_state = INIT_WAIT1;
            INIT_WAIT1: if (bus.acc_done || abandon) next_state = IDLE;
            IDLE: begin
                if (bus.wr_req)                   next_state = ISSUE_WR;
                else if (pending || tick_refresh) next_state = ISSUE_RD;
            end
            ISSUE_WR:   next_state = WAIT_WR;
            WAIT_WR:    if (bus.acc_done || abandon) next_state = WR_ACK;
            WR_ACK:     next_state = NEXT;
            ISSUE_RD:   next_state = WAIT_RD;
            WAIT_RD: begin
                if (bus.acc_done)  next_state = RD_OUT;
                else if (abandon)  next_state = NEXT;
            end
            RD_OUT:     next_state = NEXT;
            NEXT: begin
                if (bus.wr_req)      next_state = ISSUE_WR;
                else if (more_reads) next_state = ISSUE_RD;
                else                 next_state = IDLE;
            end
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.acc_start = 1'b0;
        bus.acc_wr    = 1'b0;
        bus.acc_addr  = 8'h00;
        bus.acc_wdata = 8'h00;
        bus.wr_ack    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_index  = 4'd0;
        bus.rd_data   = 8'h00;
        sweep_done    = 1'b0;
        busy          = live && (state != IDLE);
        case (state)
            INIT_W0: if (live) begin
                bus.acc_start = 1'b1;
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = 8'h02;
                bus.acc_wdata = 8'h10;
            end
            INIT_WAIT0: begin
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = 8'h02;
                bus.acc_wdata = 8'h10;
            end
            INIT_W1: begin
                bus.acc_start = 1'b1;
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = 8'h02;
            end
            INIT_WAIT1: begin
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = 8'h02;
            end
            ISSUE_WR: begin
                bus.acc_start = 1'b1;
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = bus.wr_addr;
                bus.acc_wdata = bus.wr_data;
            end
            WAIT_WR: begin
                bus.acc_wr    = 1'b1;
                bus.acc_addr  = wr_addr_q;
                bus.acc_wdata = wr_data_q;
            end
            WR_ACK:   bus.wr_ack = 1'b1;
            ISSUE_RD: begin
                bus.acc_start = 1'b1;
                bus.acc_addr  = sweep_addr(ptr);
            end
            WAIT_RD:  bus.acc_addr = sweep_addr(ptr);
            RD_OUT: begin
                bus.rd_valid = 1'b1;
                bus.rd_index = ptr;
                bus.rd_data  = rdata_q;
            end
            NEXT:     sweep_done = !bus.wr_req && sweep_active && !more_reads;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            live         <= 1'b0;
            ptr          <= 4'd0;
            pending      <= 1'b0;
            sweep_active <= 1'b0;
            wr_addr_q    <= 8'h00;
            wr_data_q    <= 8'h00;
            rdata_q      <= 8'h00;
        end else begin
            live <= 1'b1;
            if (state == ISSUE_WR) begin
                wr_addr_q <= bus.wr_addr;
                wr_data_q <= bus.wr_data;
            end
            if (state == WAIT_RD && bus.acc_done) rdata_q <= bus.acc_rdata;
            if (state == RD_OUT || (state == WAIT_RD && abandon)) ptr <= ptr + 4'd1;
            // A tick seen in IDLE starts the sweep directly; any other tick is remembered.
            if (state == IDLE && next_state == ISSUE_RD) begin
                ptr          <= 4'd0;
                sweep_active <= 1'b1;
                pending      <= 1'b0;
            end else if (tick_refresh && (state != IDLE || bus.wr_req)) begin
                pending <= 1'b1;
            end
            if (state == NEXT && next_state == IDLE) sweep_active <= 1'b0;
        end
    end

endmodule
